// File: rtl/adc_segment_sequencer_if.sv
// rtl/adc_segment_sequencer_if.sv - arm/config/trigger inputs and capture status of the segment sequencer
interface adc_segment_sequencer_if #(
  parameter int pNUM_TRIG = 4,
  parameter int pSAMPLE_W = 32,
  parameter int pPRE_W    = 15,
  parameter int pSEG_W    = 16,
  parameter int pDS_W     = 13
);
  logic                 arm_usb;
  logic [pNUM_TRIG-1:0] trig_in;
  logic [pNUM_TRIG-1:0] trig_mask;
  logic [pNUM_TRIG-1:0] trig_invert;
  logic                 trig_level_mode;
  logic                 trig_now;
  logic [pPRE_W-1:0]    presamples;
  logic [pSAMPLE_W-1:0] offset;
  logic [pSAMPLE_W-1:0] samples;
  logic [pDS_W-1:0]     downsample;
  logic [pSEG_W-1:0]    num_segments;
  logic [pSAMPLE_W-1:0] segment_cycles;
  logic                 seg_cycle_en;
  logic                 capture_we;
  logic                 armed;
  logic                 done;
  logic [pSEG_W-1:0]    seg_idx;
  logic                 seg_overrun;
  logic [31:0]          trig_duration;

  modport master (
    output arm_usb, trig_in, trig_mask, trig_invert, trig_level_mode, trig_now,
           presamples, offset, samples, downsample, num_segments, segment_cycles, seg_cycle_en,
    input  capture_we, armed, done, seg_idx, seg_overrun, trig_duration
  );

  modport slave (
    input  arm_usb, trig_in, trig_mask, trig_invert, trig_level_mode, trig_now,
           presamples, offset, samples, downsample, num_segments, segment_cycles, seg_cycle_en,
    output capture_we, armed, done, seg_idx, seg_overrun, trig_duration
  );
endinterface

// File: rtl/adc_segment_sequencer.sv
// rtl/adc_segment_sequencer.sv - multi-source trigger and segmented-capture sequencer in the ADC sample domain
module adc_segment_sequencer #(
  parameter int pNUM_TRIG = 4,
  parameter int pSAMPLE_W = 32,
  parameter int pPRE_W    = 15,
  parameter int pSEG_W    = 16,
  parameter int pDS_W     = 13
) (
  input  logic                   adc_sampleclk,
  input  logic                   reset,
  adc_segment_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_OFFSET, S_CAPTURE, S_SEG_WAIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic                 r_arm_s1, r_arm_s2, r_arm_d;
  logic                 r_trig_r, r_trig_r_d;
  logic [pNUM_TRIG-1:0] r_mask, r_invert;
  logic                 r_level, r_segcyc_en;
  logic [pPRE_W-1:0]    r_pre, r_pre_cnt;
  logic [pSAMPLE_W-1:0] r_offset, r_samples, r_segcyc;
  logic [pSAMPLE_W-1:0] r_off_cnt, r_samp_cnt, r_seg_tmr;
  logic [pDS_W-1:0]     r_ds, r_ds_cnt;
  logic [pSEG_W-1:0]    r_nseg, r_seg_idx;
  logic                 r_overrun, r_dur_run;
  logic [31:0]          r_dur;

  logic w_arm_rise, w_arm_fall, w_trig_c, w_event, w_keep, w_pre_full;
  logic w_seg_start, w_off_last, w_samp_last, w_seg_last, w_tmr_hit, w_cap_end;
  logic w_capture_we, w_armed, w_done;
  logic [pSAMPLE_W-1:0] w_samp_m1, w_segcyc_m1;
  logic [pSEG_W-1:0]    w_nseg_m1;

  assign w_arm_rise  = r_arm_s2 & ~r_arm_d;
  assign w_arm_fall  = ~r_arm_s2 & r_arm_d;
  assign w_trig_c    = (|((bus.trig_in ^ r_invert) & r_mask)) | bus.trig_now;
  assign w_event     = r_level ? r_trig_r : (r_trig_r & ~r_trig_r_d);
  assign w_keep      = (r_ds_cnt == '0);
  assign w_pre_full  = (r_pre_cnt == r_pre);

  // Zero samples / segments / spacing behave as one.
  assign w_samp_m1   = (r_samples == '0) ? '0 : r_samples - pSAMPLE_W'(1);
  assign w_nseg_m1   = (r_nseg == '0) ? '0 : r_nseg - pSEG_W'(1);
  assign w_segcyc_m1 = (r_segcyc == '0) ? '0 : r_segcyc - pSAMPLE_W'(1);

  assign w_off_last  = (r_off_cnt == r_offset - pSAMPLE_W'(1));
  assign w_samp_last = (r_samp_cnt == w_samp_m1);
  assign w_seg_last  = (r_seg_idx == w_nseg_m1);
  assign w_tmr_hit   = (r_seg_tmr == w_segcyc_m1);
  assign w_cap_end   = (r_state == S_CAPTURE) & w_keep & w_samp_last;
  assign w_seg_start = ((r_state == S_ARMED) & w_pre_full & w_event) |
                       ((r_state == S_SEG_WAIT) & (r_segcyc_en ? w_tmr_hit : w_event));

  always_ff @(posedge adc_sampleclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_arm_fall) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:               if (w_arm_rise) w_next = S_ARMED;
        S_ARMED, S_SEG_WAIT:  if (w_seg_start) w_next = (r_offset != '0) ? S_OFFSET : S_CAPTURE;
        S_OFFSET:             if (w_off_last) w_next = S_CAPTURE;
        S_CAPTURE:            if (w_cap_end) w_next = w_seg_last ? S_DONE : S_SEG_WAIT;
        S_DONE:               w_next = S_DONE;
        default:              w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture_we = 1'b0;
    w_armed      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_ARMED:             begin w_armed = 1'b1; w_capture_we = w_keep & ~w_pre_full; end
      S_OFFSET, S_SEG_WAIT: w_armed = 1'b1;
      S_CAPTURE:           begin w_armed = 1'b1; w_capture_we = w_keep; end
      S_DONE:               w_done = 1'b1;
      default:             begin end
    endcase
  end

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      r_arm_s1 <= 1'b0;  r_arm_s2 <= 1'b0;  r_arm_d <= 1'b0;
      r_trig_r <= 1'b0;  r_trig_r_d <= 1'b0;
      r_mask <= '0;  r_invert <= '0;  r_level <= 1'b0;  r_segcyc_en <= 1'b0;
      r_pre <= '0;  r_offset <= '0;  r_samples <= '0;  r_segcyc <= '0;
      r_ds <= '0;  r_nseg <= '0;
      r_pre_cnt <= '0;  r_ds_cnt <= '0;  r_off_cnt <= '0;  r_samp_cnt <= '0;  r_seg_tmr <= '0;
      r_seg_idx <= '0;  r_overrun <= 1'b0;  r_dur <= '0;  r_dur_run <= 1'b0;
    end else begin
      r_arm_s1   <= bus.arm_usb;
      r_arm_s2   <= r_arm_s1;
      r_arm_d    <= r_arm_s2;
      r_trig_r   <= w_trig_c;
      r_trig_r_d <= r_trig_r;

      if (r_state == S_IDLE && w_arm_rise) begin
        r_mask      <= bus.trig_mask;
        r_invert    <= bus.trig_invert;
        r_level     <= bus.trig_level_mode;
        r_segcyc_en <= bus.seg_cycle_en;
        r_pre       <= bus.presamples;
        r_offset    <= bus.offset;
        r_samples   <= bus.samples;
        r_segcyc    <= bus.segment_cycles;
        r_ds        <= bus.downsample;
        r_nseg      <= bus.num_segments;
        r_pre_cnt   <= '0;
        r_ds_cnt    <= '0;
        r_seg_idx   <= '0;
        r_overrun   <= 1'b0;
        r_dur       <= '0;
        r_dur_run   <= 1'b0;
      end else begin
        if (w_next == S_CAPTURE && r_state != S_CAPTURE) r_ds_cnt <= '0;
        else if (r_ds_cnt == r_ds)                        r_ds_cnt <= '0;
        else                                              r_ds_cnt <= r_ds_cnt + pDS_W'(1);

        if (r_state == S_ARMED && w_capture_we) r_pre_cnt <= r_pre_cnt + pPRE_W'(1);

        if (w_seg_start)              r_off_cnt <= '0;
        else if (r_state == S_OFFSET) r_off_cnt <= r_off_cnt + pSAMPLE_W'(1);

        if (r_state != S_CAPTURE) r_samp_cnt <= '0;
        else if (w_capture_we)    r_samp_cnt <= r_samp_cnt + pSAMPLE_W'(1);

        // Timer holds once it hits so a late capture end still sees it expired.
        if (w_seg_start)     r_seg_tmr <= '0;
        else if (!w_tmr_hit) r_seg_tmr <= r_seg_tmr + pSAMPLE_W'(1);

        if (w_cap_end && !w_seg_last && !w_arm_fall) begin
          r_seg_idx <= r_seg_idx + pSEG_W'(1);
          if (r_segcyc_en && w_tmr_hit) r_overrun <= 1'b1;
        end

        if (r_state == S_ARMED && w_seg_start) begin
          r_dur     <= 32'd1;
          r_dur_run <= 1'b1;
        end else if (r_dur_run) begin
          if (!r_trig_r)           r_dur_run <= 1'b0;
          else if (r_dur != '1)    r_dur <= r_dur + 32'd1;
        end
      end
    end
  end

  assign bus.capture_we    = w_capture_we;
  assign bus.armed         = w_armed;
  assign bus.done          = w_done;
  assign bus.seg_idx       = r_seg_idx;
  assign bus.seg_overrun   = r_overrun;
  assign bus.trig_duration = r_dur;

endmodule
